// File: rtl/rand_pkg.sv
// Shared definitions for the 16-bit LFSR and the word packer that consumes its bits.
package rand_pkg;

    localparam int LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hECEB;

    // IDLE: not requesting, FILL: requesting a bit, STALL: wants to run but no slot is free
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        STALL = 2'b10
    } packer_state_t;

endpackage

// File: rtl/rand_word_fifo.sv
// DEPTH x WIDTH output buffer with occupancy count and synchronous flush.
module rand_word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rd_ptr];

    // Push into a full buffer alongside a pop is legal: the slot was reserved upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rand_word_packer.sv
// Throttles the LFSR one bit per request, packs bits LSB-first into WIDTH-bit words
// and hands them out through a small valid/ready buffer without ever dropping a bit.
module rand_word_packer
    import rand_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    output logic             lfsr_en,
    input  logic             lfsr_rand_bit,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      words_out,
    output logic             busy
);
    localparam int RW = $clog2(WIDTH + 1);
    localparam int AW = $clog2(WIDTH);
    localparam int SW = $clog2(DEPTH + 1);
    localparam logic [RW-1:0] REQ_FULL = RW'(WIDTH);
    localparam logic [AW-1:0] ARR_LAST = AW'(WIDTH - 1);
    localparam logic [SW-1:0] SLOTS    = SW'(DEPTH);

    packer_state_t    state;
    logic             en_q;
    logic [RW-1:0]    req_cnt;
    logic [RW-1:0]    req_after;
    logic [AW-1:0]    arr_cnt;
    logic [SW-1:0]    reserved;
    logic [SW-1:0]    res_after;
    logic [SW-1:0]    fifo_count;
    logic [WIDTH-2:0] acc;
    logic [WIDTH-1:0] push_word;
    logic             start;
    logic             pop;
    logic             push;
    logic             can_req;

    assign lfsr_en   = (state == FILL);
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = en_q & (arr_cnt == ARR_LAST);
    assign push_word = {lfsr_rand_bit, acc};
    assign start     = lfsr_en & ((req_cnt == '0) | (req_cnt == REQ_FULL));
    assign busy      = en_q | (arr_cnt != '0);

    // Look ahead to the state after this edge: a request issued now may open a new
    // word (reserving a slot), and a pop now frees one.
    always_comb begin
        req_after = req_cnt;
        if (start) begin
            req_after = RW'(1);
        end else if (lfsr_en) begin
            req_after = req_cnt + 1'b1;
        end
        res_after = reserved + SW'(start) - SW'(pop);
        can_req   = 1'b1;
        if ((req_after == '0) || (req_after == REQ_FULL)) begin
            can_req = (res_after < SLOTS);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            en_q      <= 1'b0;
            req_cnt   <= '0;
            arr_cnt   <= '0;
            reserved  <= '0;
            acc       <= '0;
            words_out <= '0;
        end else if (clr) begin
            state    <= IDLE;
            en_q     <= 1'b0;
            req_cnt  <= '0;
            arr_cnt  <= '0;
            reserved <= '0;
            acc      <= '0;
        end else begin
            if (!run) begin
                state <= IDLE;
            end else if (can_req) begin
                state <= FILL;
            end else begin
                state <= STALL;
            end
            en_q     <= lfsr_en;
            req_cnt  <= req_after;
            reserved <= res_after;
            if (pop) begin
                words_out <= words_out + 32'd1;
            end
            if (en_q) begin
                if (push) begin
                    acc     <= '0;
                    arr_cnt <= '0;
                end else begin
                    acc[arr_cnt] <= lfsr_rand_bit;
                    arr_cnt      <= arr_cnt + 1'b1;
                end
            end
        end
    end

    rand_word_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (clr),
        .push     (push),
        .push_data(push_word),
        .pop      (pop),
        .head     (out_data),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_rand_word_packer.sv
// Directed bench: behavioural LFSR feeding two packers (WIDTH 16 and 8), stream scoreboard.
module tb_rand_word_packer;
    import rand_pkg::*;

    localparam int W    = 16;
    localparam int NREF = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        clr;
    logic        out_ready;
    logic        out_ready8;
    logic        lfsr_en;
    logic        lfsr_rand_bit;
    logic [W-1:0] out_data;
    logic        out_valid;
    logic [31:0] words_out;
    logic        busy;
    logic        lfsr_en8;
    logic        rand_bit8;
    logic [7:0]  out_data8;
    logic        out_valid8;
    logic [31:0] words_out8;
    logic        busy8;

    logic        ref_bits [NREF];
    int          req_total;
    int          req_total8;
    int          exp_pos;
    logic [31:0] mon_pops;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  words8 [2];
    int          cnt8 = 0;

    always #5 clk = ~clk;

    rand_word_packer #(.WIDTH(W), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .clr(clr),
        .lfsr_en(lfsr_en), .lfsr_rand_bit(lfsr_rand_bit),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .words_out(words_out), .busy(busy)
    );

    rand_word_packer #(.WIDTH(8), .DEPTH(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .run(run), .clr(clr),
        .lfsr_en(lfsr_en8), .lfsr_rand_bit(rand_bit8),
        .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8),
        .words_out(words_out8), .busy(busy8)
    );

    // Each LFSR model emits its next reference bit the cycle after a request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_total     <= 0;
            lfsr_rand_bit <= 1'b0;
        end else if (lfsr_en) begin
            lfsr_rand_bit <= ref_bits[req_total];
            req_total     <= req_total + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_total8 <= 0;
            rand_bit8  <= 1'b0;
        end else if (lfsr_en8) begin
            rand_bit8  <= ref_bits[req_total8];
            req_total8 <= req_total8 + 1;
        end
    end

    function automatic logic [31:0] ref_word(input int pos, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = ref_bits[pos + i];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic rdy);
        @(posedge clk);
        #1;
        run       = r;
        clr       = c;
        out_ready = rdy;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checkOutput("stream_word", 32'(out_data), ref_word(exp_pos, W));
            exp_pos  = exp_pos + W;
            mon_pops = mon_pops + 32'd1;
        end
        if (rst_n && out_valid8 && out_ready8 && cnt8 < 2) begin
            words8[cnt8] = out_data8;
            cnt8         = cnt8 + 1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [LFSR_WIDTH-1:0] sr;
        int  lat;
        int  base;
        int  target;
        bit  found;

        sr = LFSR_SEED;
        for (int i = 0; i < NREF; i++) begin
            ref_bits[i] = sr[0];
            sr = {sr[0] ^ sr[2] ^ sr[3] ^ sr[5], sr[15:1]};
        end

        rst_n      = 1'b0;
        run        = 1'b0;
        clr        = 1'b0;
        out_ready  = 1'b1;
        out_ready8 = 1'b1;
        exp_pos    = 0;
        mon_pops   = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_lfsr_en", 32'(lfsr_en), 32'd0);
        checkOutput("rst_words_out", words_out, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst8_words_out", words_out8, 32'd0);
        checkOutput("rst8_busy", 32'(busy8), 32'd0);
        rst_n = 1'b1;

        // Continuous run: first word 18 cycles after run rises, then one every 16.
        applyStimulus(1'b1, 1'b0, 1'b1);
        lat   = 0;
        found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat   = i;
                found = 1'b1;
            end
        end
        checkOutput("first_latency", 32'(lat), 32'd18);
        checkOutput("first_word", 32'(out_data), 32'hECEB);
        repeat (63) @(negedge clk);
        checkOutput("stream_words_out", words_out, 32'd4);
        checkOutput("stream_gap_valid", 32'(out_valid), 32'd0);
        checkOutput("stream_lfsr_en", 32'(lfsr_en), 32'd1);
        checkOutput("stream_busy", 32'(busy), 32'd1);
        checkOutput("w8_count", 32'(cnt8), 32'd2);
        checkOutput("w8_word0", 32'(words8[0]), 32'hEB);
        checkOutput("w8_word1", 32'(words8[1]), 32'hEC);

        // Backpressure: two words buffered, requests stop after bit 96.
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        checkOutput("bp_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_lfsr_en", 32'(lfsr_en), 32'd0);
        checkOutput("bp_busy", 32'(busy), 32'd0);
        checkOutput("bp_req_total", 32'(req_total), 32'd96);
        checkOutput("bp_head", 32'(out_data), ref_word(64, W));
        checkOutput("bp_words_out", words_out, 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 300 && mon_pops < 32'd9; i++) @(negedge clk);
        checkOutput("bp_resume", 32'(mon_pops >= 32'd9), 32'd1);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(~run, 1'b0, 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("toggle_count", words_out, mon_pops);
        checkOutput("toggle_progress", 32'(mon_pops > 32'd12), 32'd1);

        // Flush with one complete word buffered, five bits packed and one bit in flight.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        base    = req_total;
        exp_pos = req_total;
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (22) @(posedge clk);
        #1 run = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("pre_clr_valid", 32'(out_valid), 32'd1);
        checkOutput("pre_clr_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("clr_valid", 32'(out_valid), 32'd0);
        checkOutput("clr_busy", 32'(busy), 32'd0);
        checkOutput("clr_lfsr_en", 32'(lfsr_en), 32'd0);
        checkOutput("clr_words_out", words_out, mon_pops);
        checkOutput("clr_req_total", 32'(req_total), 32'(base + 22));
        exp_pos = req_total;
        target  = int'(mon_pops) + 2;
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 200 && int'(mon_pops) < target; i++) @(negedge clk);
        checkOutput("clr_resume", 32'(int'(mon_pops) >= target), 32'd1);

        // words_out wraps from all-ones to zero on a pop.
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (60) @(negedge clk);
        checkOutput("wrap_valid", 32'(out_valid), 32'd1);
        checkOutput("wrap_pre_count", words_out, mon_pops);
        force dut.words_out = 32'hFFFF_FFFF;
        #1 release dut.words_out;
        checkOutput("wrap_head", 32'(out_data), ref_word(exp_pos, W));
        exp_pos   = exp_pos + W;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("wrap_words_out", words_out, 32'd0);
        mon_pops = '0;

        // Asynchronous reset mid-cycle clears outputs without waiting for a clock edge.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_out_data", 32'(out_data), 32'd0);
        checkOutput("arst_lfsr_en", 32'(lfsr_en), 32'd0);
        checkOutput("arst_words_out", words_out, 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        exp_pos  = 0;
        mon_pops = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = out_valid;
        end
        checkOutput("post_rst_found", 32'(found), 32'd1);
        checkOutput("post_rst_word", 32'(out_data), 32'hECEB);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rand_word_packer.md
Name: rand_word_packer

Overview:
- Sits directly downstream of the 16-bit maximal-length LFSR (`lfsr`, ports `en` / `rand_bit` / `shift_reg`).
- Drives the LFSR's `en`, collects successive `rand_bit` values LSB-first into WIDTH-bit words, and delivers them through a DEPTH-entry output buffer with valid/ready handshake.
- Throttles the LFSR so no generated bit is ever lost.

Parameters:
- WIDTH, 16, bits per output word (legal 2..32).
- DEPTH, 2, output buffer entries (legal 1..4).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level; allow new bit requests while high.
- clr  input  1  synchronous flush of buffer, partial word and in-flight bit.
- lfsr_en  output  1  to LFSR `en`; one bit requested per high cycle.
- lfsr_rand_bit  input  1  from LFSR `rand_bit`; valid the cycle after the request.
- out_data  output  WIDTH  head-of-buffer word.
- out_valid  output  1  buffer non-empty.
- out_ready  input  1  consumer accepts head on posedge when out_valid & out_ready.
- words_out  output  32  count of accepted words; wraps 0xFFFFFFFF -> 0.
- busy  output  1  high when a partial word or in-flight bit exists.

Behaviour:
- Reset (rst_n low, asynchronous): buffer empty; out_valid=0, out_data=0, lfsr_en=0, words_out=0, busy=0; all counters 0.
- Request/arrival timing:
  - lfsr_en is registered.
  - The bit requested in cycle t is sampled from lfsr_rand_bit at the posedge ending cycle t+1, tracked by internal en_q.
- Packing:
  - The k-th arriving bit of a word (k = 0..WIDTH-1) is written to acc[k].
  - When bit WIDTH-1 arrives, acc with that bit is pushed into the buffer on the same edge, and the accumulator clears.
- Counters and reservation:
  - req_cnt (0..WIDTH) counts bits requested for the current word.
  - A buffer slot is reserved when the first bit of a word is requested.
  - reserved = occupancy + (word in progress).
  - A new word may start only if reserved < DEPTH; a push therefore never overflows.
- lfsr_en is high next cycle iff all of the following hold:
  - run=1 and clr=0;
  - either req_cnt < WIDTH within a started word, or a new word may start (reserved < DEPTH, counting a pop on this edge as freeing a slot).
- Throughput: with out_ready held high and run high, one bit per cycle; words are back-to-back.
  - First out_valid occurs WIDTH+2 cycles after run rises (1 cycle request register, WIDTH requests, 1 cycle arrival).
- run deassert mid-word: stop issuing; in-flight bits still land. Resume on run high continues the same word without loss.
- Buffer: FIFO order.
  - Simultaneous push and pop when full: legal (the slot was reserved); occupancy unchanged.
  - Pop when empty: impossible (out_valid=0).
- clr: on the edge it is sampled, all of the following happen:
  - buffer emptied, acc/req_cnt/en_q cleared;
  - the bit in flight from a prior request is discarded;
  - lfsr_en=0 for that next cycle;
  - words_out is NOT cleared.
  - clr has priority over push/pop on the same edge.
- out_data holds its value while out_valid & !out_ready; no change until pop.
- words_out increments on each pop.
- Reset mid-word: state is lost immediately; the LFSR is reset independently by its own reset.

Decomposition:
- Package rand_pkg:
  - LFSR_SEED = 16'hECEB;
  - LFSR_WIDTH = 16;
  - typedef packer_state_t {IDLE, FILL, STALL} for debug visibility of the request FSM;
  - shared by the LFSR bench and this block's bench.
- One sub-module: rand_word_fifo (DEPTH x WIDTH, push/pop/count, synchronous flush).
- Request logic, accumulator and counters stay in the top.

Test Plan:
- Seed/first word: LFSR reset to 0xECEB, WIDTH=16, run=1, out_ready=1 -> first word 0xECEB at cycle 18 after run; subsequent words match the bench reference model, one word per 16 cycles.
- WIDTH=8: same setup -> first two words 0xEB then 0xEC.
- Backpressure: out_ready=0, DEPTH=2 -> exactly 2 words buffered, lfsr_en stays low after 32 requests, busy=0. Then out_ready=1 -> stream resumes with no skipped LFSR bits (model comparison).
- run toggled at random every 0-3 cycles -> words identical to the continuous-run sequence.
- clr asserted one cycle after lfsr_en while partial word holds 5 bits -> out_valid=0 and busy=0 the next cycle. The next word equals model bits starting after all bits requested before clr (discarded bits counted), and words_out is unchanged.
- words_out preset via force to 0xFFFFFFFF, one pop -> words_out=0; async rst_n pulse mid-cycle -> all outputs 0 immediately.
